// File: rtl/audio_playout_buffer_if.sv
// Packet-in / sample-out bus of the audio playout buffer.
// Latency: n/a (signal bundle only).
// Backpressure: none; in_valid is a fire-and-forget pulse, out_valid a per-tick pulse.
//
// Signals:
//   in_valid / in_audio / in_seq / in_device : one accepted packet per in_valid pulse
//   out_sample / out_device                  : current played sample, held between ticks
//   out_valid / out_underrun                 : tick pulse, underrun qualifier
// Modports: master = packet source / sample sink, slave = the buffer itself.

interface audio_playout_buffer_if;
    logic        in_valid;
    logic [15:0] in_audio;
    logic [7:0]  in_seq;
    logic [7:0]  in_device;

    logic [15:0] out_sample;
    logic [7:0]  out_device;
    logic        out_valid;
    logic        out_underrun;

    modport master (
        output in_valid, in_audio, in_seq, in_device,
        input  out_sample, out_device, out_valid, out_underrun
    );

    modport slave (
        input  in_valid, in_audio, in_seq, in_device,
        output out_sample, out_device, out_valid, out_underrun
    );
endinterface

// File: rtl/audio_playout_buffer.sv
// Circular sample FIFO with sequence-continuity check and divided-rate playout.
// Latency: a write is visible in fifo_count the next cycle; a played sample appears
//          the cycle after its tick.
// Backpressure: none upstream; packets arriving on a full FIFO with no pop are dropped
//               and counted in overflow_cnt.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : packet input and sample output (see audio_playout_buffer_if)
//   play_en       : level, enables playout; flush : one-cycle synchronous clear
//   fifo_count, full, empty        : FIFO occupancy status
//   seq_error                      : one-cycle pulse on a duplicate or a gap
//   overflow_cnt, seq_gap_cnt, underrun_cnt : saturating 8-bit diagnostics

module audio_playout_buffer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int SAMPLE_DIV  = 8,
    parameter int PREFILL_LVL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    audio_playout_buffer_if.slave  bus,
    input  logic                   play_en,
    input  logic                   flush,
    output logic [ADDR_W:0]        fifo_count,
    output logic                   full,
    output logic                   empty,
    output logic                   seq_error,
    output logic [7:0]             overflow_cnt,
    output logic [7:0]             seq_gap_cnt,
    output logic [7:0]             underrun_cnt
);

    localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W:0]   FULL_CNT    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   PREFILL_CNT = (ADDR_W + 1)'(PREFILL_LVL);

    typedef struct packed {
        logic [7:0]  device;
        logic [15:0] audio;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        PLAY    = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t            mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic [7:0]        expected_seq;
    logic              seq_armed;

    state_t            state_q;
    state_t            state_d;
    logic [DIV_W-1:0]  div_q;

    logic [15:0]       out_sample_q;
    logic [7:0]        out_device_q;
    logic              out_valid_q;
    logic              out_underrun_q;

    // ------------------------------------------------------------------
    // Datapath decisions
    // ------------------------------------------------------------------
    logic pkt;      // packet that takes part in tracking (flush discards it)
    logic is_dup;
    logic in_order;
    logic tick;
    logic pop;
    logic push;
    logic drop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign pkt = bus.in_valid && !flush;

    // The duplicate test is only meaningful once a first sequence number
    // has been seen; before that every value is accepted as the start.
    assign is_dup   = seq_armed && (bus.in_seq == expected_seq - 8'd1);
    assign in_order = !seq_armed || (bus.in_seq == expected_seq);

    // A tick is cancelled by play_en dropping or by flush in the same cycle.
    assign tick = (state_q == PLAY) && play_en && !flush && (div_q == DIV_LAST);
    assign pop  = tick && !empty;

    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign push = pkt && !is_dup && (!full || pop);
    assign drop = pkt && !is_dup && full && !pop;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{device: bus.in_device, audio: bus.in_audio};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign fifo_count = count;

    // ------------------------------------------------------------------
    // Sequence tracker
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_armed    <= 1'b0;
            expected_seq <= 8'd0;
            seq_error    <= 1'b0;
            seq_gap_cnt  <= 8'd0;
        end else begin
            seq_error <= pkt && !in_order;
            if (flush) begin
                seq_armed <= 1'b0;
            end else if (pkt) begin
                seq_armed <= 1'b1;
                // A duplicate leaves the expectation where it was; in-order,
                // gap and overflow-dropped packets all resynchronise to it.
                if (!is_dup) begin
                    expected_seq <= bus.in_seq + 8'd1;
                end
                if (!in_order) begin
                    seq_gap_cnt <= sat_inc(seq_gap_cnt);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Playout FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = play_en ? PREFILL : IDLE;
        end else if (!play_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PREFILL;
                PREFILL: if (count >= PREFILL_CNT) state_d = PLAY;
                PLAY:    if (tick && empty) state_d = PREFILL;
                default: state_d = IDLE;
            endcase
        end
    end

    // The divider only runs while staying in PLAY, so it is zero on every
    // entry into PLAY and the first tick lands SAMPLE_DIV cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (state_q == PLAY && state_d == PLAY) begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end else begin
            div_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Output sample register and diagnostics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sample_q   <= 16'd0;
            out_device_q   <= 8'd0;
            out_valid_q    <= 1'b0;
            out_underrun_q <= 1'b0;
            overflow_cnt   <= 8'd0;
            underrun_cnt   <= 8'd0;
        end else begin
            out_valid_q    <= tick;
            out_underrun_q <= tick && empty;
            // On underrun the previous sample is simply held and repeated.
            if (pop) begin
                out_sample_q <= mem[rd_ptr].audio;
                out_device_q <= mem[rd_ptr].device;
            end
            if (drop) begin
                overflow_cnt <= sat_inc(overflow_cnt);
            end
            if (tick && empty) begin
                underrun_cnt <= sat_inc(underrun_cnt);
            end
        end
    end

    assign bus.out_sample   = out_sample_q;
    assign bus.out_device   = out_device_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_underrun = out_underrun_q;

endmodule

// File: tb/tb_audio_playout_buffer.sv
// Directed bench for audio_playout_buffer: playout timing, sequence checks,
// overflow, push/pop on full, flush and mid-playout reset.
// Inputs are driven 1 time unit after the rising edge and sampled there too.

module tb_audio_playout_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        play_en;
    logic        flush;
    logic [4:0]  fifo_count;
    logic        full;
    logic        empty;
    logic        seq_error;
    logic [7:0]  overflow_cnt;
    logic [7:0]  seq_gap_cnt;
    logic [7:0]  underrun_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_playout_buffer_if bus ();

    audio_playout_buffer #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .SAMPLE_DIV  (8),
        .PREFILL_LVL (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .play_en      (play_en),
        .flush        (flush),
        .fifo_count   (fifo_count),
        .full         (full),
        .empty        (empty),
        .seq_error    (seq_error),
        .overflow_cnt (overflow_cnt),
        .seq_gap_cnt  (seq_gap_cnt),
        .underrun_cnt (underrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] seq, input logic [15:0] audio, input logic [7:0] dev);
        bus.in_valid  = 1'b1;
        bus.in_seq    = seq;
        bus.in_audio  = audio;
        bus.in_device = dev;
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Cycles until out_valid is seen (bounded); -1 when the budget expires.
    task automatic wait_valid(output int n);
        bit seen;
        n    = -1;
        seen = 1'b0;
        for (int i = 1; i <= 64 && !seen; i++) begin
            step();
            if (bus.out_valid) begin
                n    = i;
                seen = 1'b1;
            end
        end
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.out_valid) n++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sample"},   bus.out_sample,   16'h0000);
        check({tag, "_device"},   bus.out_device,   8'h00);
        check({tag, "_valid"},    bus.out_valid,    1'b0);
        check({tag, "_underrun"}, bus.out_underrun, 1'b0);
        check({tag, "_count"},    fifo_count,       5'd0);
        check({tag, "_empty"},    empty,            1'b1);
        check({tag, "_full"},     full,             1'b0);
        check({tag, "_seqerr"},   seq_error,        1'b0);
        check({tag, "_ovf"},      overflow_cnt,     8'd0);
        check({tag, "_gap"},      seq_gap_cnt,      8'd0);
        check({tag, "_urun"},     underrun_cnt,     8'd0);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        play_en       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_seq    = 8'd0;
        bus.in_audio  = 16'd0;
        bus.in_device = 8'd0;
        #3;
        check_reset_values("rst0");
        step();
        step();
        rst_n = 1'b1;
        step();

        // ---- 1: prefill 4, play 4 samples, then an underrun tick ----
        for (int i = 0; i < 4; i++) send(8'(10 + i), 16'(16'h0011 + i), 8'h5A);
        check("t1_count", fifo_count, 5'd4);
        check("t1_gap",   seq_gap_cnt, 8'd0);
        play_en = 1'b1;
        // IDLE->PREFILL, PREFILL->PLAY, then 8 divider cycles to the tick.
        wait_valid(n);
        check("t1_first_lat", n, 10);
        check("t1_s0",        bus.out_sample, 16'h0011);
        check("t1_dev0",      bus.out_device, 8'h5A);
        check("t1_urun0",     bus.out_underrun, 1'b0);
        for (int i = 1; i < 4; i++) begin
            wait_valid(n);
            check("t1_period", n, 8);
            check("t1_sample", bus.out_sample, 16'(16'h0011 + i));
        end
        check("t1_empty", empty, 1'b1);
        wait_valid(n);
        check("t1_urun_period", n, 8);
        check("t1_urun_flag",   bus.out_underrun, 1'b1);
        check("t1_urun_hold",   bus.out_sample, 16'h0014);
        check("t1_urun_cnt",    underrun_cnt, 8'd1);
        // Back in PREFILL: no more ticks, so no more underruns.
        count_valid(20, n);
        check("t1_prefill_quiet", n, 0);
        check("t1_urun_cnt2",     underrun_cnt, 8'd1);

        // ---- 2: sequence checks 254, 255, 0, 0, 5 ----
        play_en = 1'b0;
        do_flush();
        send(8'd254, 16'h0254, 8'h01);
        check("t2_254_err", seq_error, 1'b0);
        send(8'd255, 16'h0255, 8'h01);
        check("t2_255_err", seq_error, 1'b0);
        send(8'd0, 16'h0300, 8'h01);
        check("t2_wrap_err", seq_error, 1'b0);
        send(8'd0, 16'h0301, 8'h01);
        check("t2_dup_err",   seq_error, 1'b1);
        check("t2_dup_count", fifo_count, 5'd3);
        step();
        check("t2_err_pulse", seq_error, 1'b0);
        send(8'd5, 16'h0305, 8'h01);
        check("t2_gap_err", seq_error, 1'b1);
        check("t2_gap_cnt", seq_gap_cnt, 8'd2);
        check("t2_count",   fifo_count, 5'd4);

        // ---- 3: overflow on the 17th packet ----
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) send(8'(100 + i), 16'(16'h0100 + i), 8'h3C);
        check("t3_full16",  full, 1'b1);
        check("t3_count16", fifo_count, 5'd16);
        check("t3_ovf16",   overflow_cnt, 8'd0);
        send(8'd116, 16'h0116, 8'h3C);
        check("t3_ovf",   overflow_cnt, 8'd1);
        check("t3_count", fifo_count, 5'd16);
        check("t3_full",  full, 1'b1);
        check("t3_gap",   seq_gap_cnt, 8'd0);

        // ---- 4: write on full coinciding with a tick pop ----
        play_en = 1'b1;
        for (int i = 0; i < 9; i++) step();
        // seq 117 follows the dropped 116, so no sequence error either.
        send(8'd117, 16'h0117, 8'h3C);
        check("t4_valid",  bus.out_valid, 1'b1);
        check("t4_sample", bus.out_sample, 16'h0100);
        check("t4_count",  fifo_count, 5'd16);
        check("t4_ovf",    overflow_cnt, 8'd1);
        check("t4_seqerr", seq_error, 1'b0);
        play_en = 1'b0;
        step();

        // ---- 5: flush with a concurrent packet ----
        do_flush();
        check("t5_flush0", fifo_count, 5'd0);
        for (int i = 0; i < 6; i++) send(8'(200 + i), 16'(16'h0200 + i), 8'h22);
        check("t5_count6", fifo_count, 5'd6);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_seq    = 8'd50;
        bus.in_audio  = 16'h0050;
        bus.in_device = 8'h22;
        step();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        check("t5_count",   fifo_count, 5'd0);
        check("t5_empty",   empty, 1'b1);
        check("t5_seqerr",  seq_error, 1'b0);
        check("t5_ovf",     overflow_cnt, 8'd1);
        check("t5_gap",     seq_gap_cnt, 8'd0);
        check("t5_urun",    underrun_cnt, 8'd0);
        check("t5_sample",  bus.out_sample, 16'h0100);
        send(8'h77, 16'h0077, 8'h44);
        check("t5_rearm_err", seq_error, 1'b0);
        check("t5_rearm_cnt", fifo_count, 5'd1);

        // ---- 6: reset in the middle of PLAY with 3 entries held ----
        for (int i = 1; i < 4; i++) send(8'(8'h77 + i), 16'(16'h0077 + i), 8'h44);
        play_en = 1'b1;
        wait_valid(n);
        check("t6_lat",    n, 10);
        check("t6_sample", bus.out_sample, 16'h0077);
        check("t6_count",  fifo_count, 5'd3);
        step();
        step();
        rst_n = 1'b0;
        #2;
        check_reset_values("t6_rst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send(8'(1 + i), 16'(16'h00A1 + i), 8'h66);
        count_valid(30, n);
        check("t6_no_play", n, 0);
        check("t6_count3",  fifo_count, 5'd3);
        send(8'd4, 16'h00A4, 8'h66);
        // Already in PREFILL: one cycle to PLAY, then 8 divider cycles.
        wait_valid(n);
        check("t6_refill_lat", n, 9);
        check("t6_refill_smp", bus.out_sample, 16'h00A1);
        check("t6_refill_dev", bus.out_device, 8'h66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_playout_buffer.md
Name: audio_playout_buffer

Overview:
Downstream stage of the audio packet processor. It captures each accepted packet's audio sample, device ID and sequence number into a circular FIFO and checks sequence-number continuity. It plays samples out at a fixed clock-divided sample rate while playback is enabled. It also keeps saturating diagnostic counters for overflow, sequence errors and underrun.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 4.
ADDR_W, 4, log2(DEPTH).
SAMPLE_DIV, 8, clk cycles per output sample; at least 2.
PREFILL_LVL, 4, entries required before playout starts; 1 to DEPTH.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  one-cycle pulse per accepted packet
in_audio  in  16  audio sample
in_seq  in  8  sequence number
in_device  in  8  device ID
play_en  in  1  level; enables playout
flush  in  1  one-cycle synchronous flush
out_sample  out  16  current output sample; held between ticks
out_device  out  8  device ID of out_sample
out_valid  out  1  one-cycle pulse per sample tick
out_underrun  out  1  qualifies out_valid: repeated sample, FIFO was empty
fifo_count  out  ADDR_W+1  occupancy, 0 to DEPTH
full  out  1  fifo_count == DEPTH
empty  out  1  fifo_count == 0
seq_error  out  1  one-cycle pulse on a sequence discontinuity
overflow_cnt  out  8  packets dropped because FIFO full; saturates at 255
seq_gap_cnt  out  8  sequence errors; saturates at 255
underrun_cnt  out  8  underrun ticks; saturates at 255

Behaviour:
- Reset values:
  - All outputs 0, except empty = 1.
  - FIFO pointers 0; state IDLE; divider 0; seq_armed = 0; expected_seq = 0.
- Write path:
  - A write takes effect on the in_valid edge when (!full or pop in the same cycle) and the entry is not a duplicate.
  - Full with no pop: drop the packet; overflow_cnt += 1.
- Sequence check, applied only when in_valid = 1:
  - seq_armed = 0: accept in_seq; expected_seq <= in_seq + 1 (mod 256); seq_armed <= 1.
  - in_seq == expected_seq: in order; expected_seq <= in_seq + 1. 255 wraps to 0, and this is not an error.
  - in_seq == expected_seq - 1 (mod 256): duplicate. Not written. seq_error pulses; seq_gap_cnt += 1.
  - Any other value: gap. The sample is still written. seq_error pulses, seq_gap_cnt += 1, expected_seq <= in_seq + 1.
  - A packet dropped for overflow still updates the sequence tracker.
- FSM, registered:
  - IDLE: out_valid = 0. If play_en = 1, go to PREFILL.
  - PREFILL: move to PLAY when fifo_count >= PREFILL_LVL. Clear the divider on entry to PLAY.
  - PLAY: divider counts 0 to SAMPLE_DIV-1. A tick occurs in the cycle the divider equals SAMPLE_DIV-1, and the divider then wraps to 0. The first tick comes SAMPLE_DIV cycles after entering PLAY.
  - Tick with FIFO non-empty: pop the head. Next cycle: out_sample/out_device = head, out_valid = 1, out_underrun = 0.
  - Tick with FIFO empty: no pop. Next cycle: out_valid = 1, out_underrun = 1, out_sample unchanged. underrun_cnt += 1. State returns to PREFILL.
  - play_en = 0 in any state: go to IDLE next cycle. Any pending tick is cancelled. FIFO contents are kept. out_sample holds its value.
- Simultaneous push and pop: fifo_count unchanged. On a full FIFO the push is accepted because a slot is freed.
- flush has priority over push and pop:
  - Pointers and count go to 0; seq_armed <= 0; state goes to PREFILL if play_en = 1, else IDLE.
  - A concurrent in_valid is discarded and not counted.
  - Diagnostic counters and out_sample are not cleared; only reset clears them.
- Reset mid-operation: immediate return to reset values; FIFO contents discarded.
- Pointer wrap: read and write pointers are ADDR_W bits wide and wrap modulo DEPTH.
- Counters saturate at 255 and never wrap.

Test Plan:
1. Reset, then 4 packets with seq 10 to 13 and audio 0x0011 to 0x0014, then play_en = 1. Expect a PLAY tick every 8 cycles; out_sample sequence 0x0011, 0x0012, 0x0013, 0x0014; then an underrun tick repeating 0x0014 with out_underrun = 1; underrun_cnt = 1; state back to PREFILL.
2. Sequence checks on seq 254, 255, 0, 0, 5:
   - seq 0 repeated: duplicate, dropped; seq_error pulses once.
   - seq 5: gap, written; seq_error pulses once.
   - The 255 -> 0 wrap gives no error.
   - Expect seq_gap_cnt = 2 and fifo_count = 4.
3. play_en = 0, then 17 packets with in-order seq. Expect full = 1 after 16, overflow_cnt = 1, fifo_count = 16, seq_gap_cnt = 0.
4. FIFO full in PLAY; in_valid coincides with a tick pop. Expect the write accepted, fifo_count stays 16, overflow_cnt unchanged.
5. flush asserted together with in_valid while 6 entries are held. Expect next cycle fifo_count = 0 and empty = 1. The next packet's seq is accepted with no seq_error. Counters retain their values.
6. Assert rst_n = 0 mid-PLAY with 3 entries held. Expect all outputs at reset values immediately, empty = 1, and no out_valid until refilled to PREFILL_LVL.
